// File: rtl/project_select_ctrl.sv
// Break-before-make project selector: drops all enables, waits a guard interval,
// then enables exactly one project (or none) and counts completed switches.
module project_select_ctrl #(
  parameter int NUM_PROJECTS = 16,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n,
  input  logic                    req_valid,
  input  logic [7:0]              req_id,
  output logic                    req_ready,
  output logic [NUM_PROJECTS-1:0] active,
  output logic [7:0]              cur_id,
  output logic                    busy,
  output logic                    err,
  input  logic                    err_clr,
  output logic [7:0]              switch_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_ACTIVE
  } state_t;

  localparam logic [7:0]              GUARD_LOAD = 8'(GUARD_CYCLES - 1);
  localparam logic [NUM_PROJECTS-1:0] ONE_LSB    = {{(NUM_PROJECTS-1){1'b0}}, 1'b1};

  state_t                  r_state;
  logic [7:0]              r_guard;
  logic [7:0]              r_tgt_id;
  logic                    r_req_ready;
  logic [NUM_PROJECTS-1:0] r_active;
  logic [7:0]              r_cur_id;
  logic                    r_busy;
  logic                    r_err;
  logic [7:0]              r_switch_count;

  logic w_accept;
  logic w_id_bad;

  assign w_accept = req_valid && r_req_ready;
  assign w_id_bad = {24'd0, req_id} >= 32'(NUM_PROJECTS);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_state        <= ST_IDLE;
      r_guard        <= '0;
      r_tgt_id       <= '0;
      r_req_ready    <= 1'b1;
      r_active       <= '0;
      r_cur_id       <= '0;
      r_busy         <= 1'b0;
      r_err          <= 1'b0;
      r_switch_count <= '0;
    end else begin
      // A new error on this edge takes priority over a clear request.
      if (w_accept && w_id_bad) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end

      case (r_state)
        ST_IDLE, ST_ACTIVE: begin
          if (w_accept) begin
            r_state     <= ST_DRAIN;
            r_guard     <= GUARD_LOAD;
            r_tgt_id    <= w_id_bad ? 8'd0 : req_id;
            r_active    <= '0;
            r_cur_id    <= '0;
            r_busy      <= 1'b1;
            r_req_ready <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (r_guard == 8'd0) begin
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            if (r_tgt_id != 8'd0) begin
              r_state  <= ST_ACTIVE;
              r_active <= ONE_LSB << r_tgt_id;
              r_cur_id <= r_tgt_id;
              if (r_switch_count != 8'hFF) begin
                r_switch_count <= r_switch_count + 8'd1;
              end
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_guard <= r_guard - 8'd1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_active    <= '0;
          r_cur_id    <= '0;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign active       = r_active;
  assign cur_id       = r_cur_id;
  assign busy         = r_busy;
  assign err          = r_err;
  assign switch_count = r_switch_count;

endmodule

// File: tb/tb_project_select_ctrl.sv
// Randomized and directed bench for project_select_ctrl; a timeline model
// predicts every output each cycle, plus pinned literal expectations.
module tb_project_select_ctrl;

  localparam int NP = 16;
  localparam int G  = 4;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic [7:0]    req_id;
  logic          req_ready;
  logic [NP-1:0] active;
  logic [7:0]    cur_id;
  logic          busy;
  logic          err;
  logic          err_clr;
  logic [7:0]    switch_count;

  int vectors    = 0;
  int miscompares = 0;

  project_select_ctrl #(.NUM_PROJECTS(NP), .GUARD_CYCLES(G)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n    (rst_n),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .req_ready   (req_ready),
    .active      (active),
    .cur_id      (cur_id),
    .busy        (busy),
    .err         (err),
    .err_clr     (err_clr),
    .switch_count(switch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a switch accepted on edge e occupies cycles e..e+G-1 with
  // everything off, and the target is live from cycle e+G onward.
  int         cyc    = 0;
  int         m_done = 0;
  int         m_tgt  = 0;
  int         m_cnt  = 0;
  logic       m_err  = 1'b0;
  bit         m_live = 1'b0;
  bit         m_was_drain;
  bit         m_bad;

  always @(posedge clk) begin
    m_was_drain = (cyc < m_done);
    cyc++;
    if (!rst_n) begin
      m_live = 1'b1;
      m_done = cyc;
      m_tgt  = 0;
      m_cnt  = 0;
      m_err  = 1'b0;
    end else if (m_live) begin
      if (cyc == m_done && m_tgt != 0 && m_cnt < 255) m_cnt++;
      if (req_valid && !m_was_drain) begin
        m_bad  = (int'(req_id) >= NP);
        m_tgt  = m_bad ? 0 : int'(req_id);
        m_done = cyc + G;
        if (m_bad) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
      end else if (err_clr) begin
        m_err = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      automatic bit       drain = (cyc < m_done);
      automatic int       ecur  = drain ? 0 : m_tgt;
      automatic logic [NP-1:0] eact = (ecur == 0) ? '0 : (NP'(1) << ecur);
      check("req_ready", 32'(req_ready), 32'(!drain));
      check("busy", 32'(busy), 32'(drain));
      check("cur_id", 32'(cur_id), 32'(ecur));
      check("active", 32'(active), 32'(eact));
      check("err", 32'(err), 32'(m_err));
      check("switch_count", 32'(switch_count), 32'(m_cnt));
      check("onehot", 32'(($countones(active) <= 1) && !active[0]), 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Holds the request until the controller takes it, then drops req_valid.
  task automatic do_req(input logic [7:0] id);
    int n = 0;
    req_valid = 1'b1;
    req_id    = id;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      miscompares++;
      $display("FAIL req_timeout: req_ready stayed %0b, required 1", req_ready);
    end
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_id    = '0;
    err_clr   = 1'b0;
    #2;
    repeat (3) step();
    rst_n = 1'b1;
    check("rst_active", 32'(active), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_count", 32'(switch_count), 32'h0);

    // First selection: id 3 live exactly G+1 cycles after the accept edge.
    do_req(8'd3);
    for (int i = 0; i < G; i++) begin
      check("sel3_drain", 32'(active), 32'h0);
      step();
    end
    check("sel3_active", 32'(active), 32'h0008);
    check("sel3_cur", 32'(cur_id), 32'd3);
    check("sel3_count", 32'(switch_count), 32'd1);

    // Switch 3 -> 7.
    do_req(8'd7);
    check("sw7_drop", 32'(active), 32'h0);
    repeat (G) step();
    check("sw7_active", 32'(active), 32'h0080);

    // Out-of-range id: error, drain, idle; then clear the error.
    do_req(8'd20);
    check("bad_err", 32'(err), 32'd1);
    repeat (G) step();
    check("bad_idle", 32'(active), 32'h0);
    check("bad_cur", 32'(cur_id), 32'd0);
    check("bad_count", 32'(switch_count), 32'd2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr", 32'(err), 32'd0);

    // Re-select of the already-active project still counts.
    do_req(8'd7);
    repeat (G) step();
    do_req(8'd7);
    repeat (G) step();
    check("resel_count", 32'(switch_count), 32'd4);

    // Requests during drain are ignored; the id present when ready returns wins.
    do_req(8'd5);
    req_valid = 1'b1;
    for (int i = 0; i < G; i++) begin
      req_id = 8'($urandom_range(1, 15));
      step();
    end
    req_id = 8'd9;
    step();
    req_valid = 1'b0;
    repeat (G) step();
    check("hold_active", 32'(active), 32'h0200);

    // Randomized traffic with bad ids, clears and occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      req_valid = ($urandom_range(0, 2) == 0);
      req_id    = 8'($urandom_range(0, 31));
      err_clr   = ($urandom_range(0, 9) == 0);
      step();
    end
    rst_n = 1'b1;
    req_valid = 1'b0;
    err_clr = 1'b0;
    repeat (G + 2) step();

    // Saturation of the switch counter.
    for (int i = 0; i < 300; i++) do_req(8'd1);
    repeat (G + 1) step();
    check("sat_count", 32'(switch_count), 32'd255);

    // Reset in the middle of a drain aborts the switch.
    do_req(8'd4);
    step();
    rst_n = 1'b0;
    step();
    check("rst_mid_active", 32'(active), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_count", 32'(switch_count), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    repeat (G + 2) step();
    check("rst_mid_after", 32'(active), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/project_select_ctrl.md
PROJECT_SELECT_CTRL -- requirements
Module: project_select_ctrl

Interface
REQ-001 SHALL have parameter NUM_PROJECTS, default 16, meaning the number of active lines; index 0 is reserved for "no project".
REQ-002 SHALL have parameter GUARD_CYCLES, default 4 (range 1..255), meaning the all-off cycles inserted between deselect and select.
REQ-003 SHALL have port wb_clk_i, input, 1, single clock; all logic rises on its posedge.
REQ-004 SHALL have port wb_rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1, a selection request is present.
REQ-006 SHALL have port req_id, input, 8, the requested project index.
REQ-007 SHALL have port req_ready, output, 1, the controller can accept a request.
REQ-008 SHALL have port active, output, NUM_PROJECTS, one-hot-or-zero enables to the wrapped projects; bit 0 is always 0.
REQ-009 SHALL have port cur_id, output, 8, index of the currently enabled project (0 = none).
REQ-010 SHALL have port busy, output, 1, high while a switch is in progress.
REQ-011 SHALL have port err, output, 1, sticky flag set when an invalid id is accepted.
REQ-012 SHALL have port err_clr, input, 1, clears err.
REQ-013 SHALL have port switch_count, output, 8, saturating count of switches completed to a nonzero project.

Function
REQ-014 SHALL implement states IDLE (no project enabled), DRAIN (all enables off, guard countdown) and ACTIVE (exactly one enable high).
REQ-015 SHALL drive req_ready=1 in IDLE and ACTIVE, and 0 in DRAIN.
REQ-016 SHALL accept a request on a cycle where req_valid && req_ready; req_id is captured on that cycle only.
REQ-017 On acceptance, the cycle after accept SHALL show active all-zero and state DRAIN, busy=1 and cur_id=0.
REQ-018 DRAIN SHALL last exactly GUARD_CYCLES cycles with active all-zero.
REQ-019 After DRAIN with a captured id in 1..NUM_PROJECTS-1, the next cycle SHALL show active[id]=1, cur_id=id, state ACTIVE, busy=0, req_ready=1, and switch_count incremented.
REQ-020 The latency from the accept edge to active[id] high SHALL be GUARD_CYCLES+1 cycles.
REQ-021 After DRAIN with a captured id of 0, the controller SHALL enter IDLE with active=0 and cur_id=0, leaving switch_count unchanged.
REQ-022 A captured id >= NUM_PROJECTS SHALL set err=1 on the cycle after accept and SHALL then be treated as id 0 (drain, then IDLE).
REQ-023 A request for the currently active id SHALL still perform the full drain and re-select sequence and SHALL increment switch_count.
REQ-024 switch_count SHALL saturate at 255 and never wrap.
REQ-025 err_clr SHALL clear err on the next edge; if err_clr and a new err-setting accept occur on the same cycle, set SHALL win.
REQ-026 req_valid while in DRAIN SHALL be ignored and not queued; the requester holds it until req_ready.
REQ-027 At no cycle SHALL more than one active bit be high (break-before-make guarantee).

Reset
REQ-028 wb_rst_n=0 at a posedge SHALL, on that edge, force IDLE, active=0, cur_id=0, busy=0, err=0, switch_count=0, req_ready=1 and guard counter=0.
REQ-029 Reset asserted mid-DRAIN or in ACTIVE SHALL abort the switch with no enable asserted afterwards.

Verification
REQ-030 Reset, then req_id=3 accepted at cycle T -> active=0 for T+1..T+4, active=16'h0008 at T+5, cur_id=3, switch_count=1.
REQ-031 Active=3, request id 7 -> bit 3 drops the cycle after accept, 4 all-zero cycles follow, then active=16'h0080; one-hot check every cycle.
REQ-032 Request id 20 -> err=1 the cycle after accept, drain, then IDLE with active=0; err_clr -> err=0 next cycle.
REQ-033 req_valid held high with a changing req_id during DRAIN -> ignored; the request is accepted only when req_ready returns, using req_id from that cycle.
REQ-034 300 switches to id 1 -> switch_count=255; wb_rst_n=0 during DRAIN -> all outputs at reset values next cycle.
